fifo_sync_prog: RTL and testbench
=================================

Name: fifo_sync_prog

Overview:
- Parametrised successor to the single-clock synchronous FIFO.
- Adds a fill-level output, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush.
- Optional first-word-fall-through read mode.
- Sits between producer/consumer datapaths in the same clock domain; storage is a register array of 2**ADDR_BITS words.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_BITS, 4, address bits; DEPTH = 2**ADDR_BITS words.
- AFULL_THRESH, 2**ADDR_BITS-2, almost_full asserted when count >= this value. Legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserted when count <= this value. Legal range 0..DEPTH-1.

Ports:
- clk_i  in  1  clock, rising-edge.
- reset_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous clear of contents.
- data_in  in  DATA_WIDTH  write data.
- w_en  in  1  write request.
- r_en  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  ADDR_BITS+1  current fill level, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (async, reset_i=1): pointers=0, count=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0. Memory contents are not cleared.
- Pointers are ADDR_BITS+1 bits. Address = low ADDR_BITS bits. Wrap is natural modulo 2**(ADDR_BITS+1).
- All status outputs are registered and reflect the state after the clock edge.
- Write accepted (wa) = w_en & (!fifo_full | ra). Writing mem[w_ptr] and incrementing w_ptr.
- Read accepted (ra) = r_en & !fifo_empty. Incrementing r_ptr.
- Full + simultaneous w_en & r_en: both accepted, count unchanged, head word popped, new word stored.
- Empty + simultaneous w_en & r_en: write accepted, read rejected, underflow pulses, count becomes 1.
- count_next = count + wa - ra.
- overflow = w_en & !wa, registered one-cycle pulse. Pulses on consecutive cycles if w_en is held.
- underflow = r_en & fifo_empty, registered one-cycle pulse.
- Standard mode read latency: on an edge where ra=1, data_out <= mem[r_ptr]. data_out is valid from that edge until the next accepted read. data_out holds its value on non-accepted cycles.
- flush_i=1 at an edge:
  - w_ptr=r_ptr=0, count=0, flags as at reset.
  - w_en/r_en in the same cycle are ignored; no overflow/underflow pulse.
  - data_out holds its value.
  - Reset has priority over flush.
- Reset asserted mid-operation discards all contents immediately, with no clock required.

Optional Feature:
- Macro: FIFO_SYNC_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[r_ptr] combinationally whenever fifo_empty=0.
  - r_en acts as a pop/acknowledge of the presented word.
  - After a write into an empty FIFO, the word appears on data_out the cycle after the write edge, when fifo_empty deasserts.
  - data_out is don't-care while empty; the bench must not check it then.
- Not defined: standard registered read with one-cycle latency, as described above.

Test Plan (DATA_WIDTH=8, ADDR_BITS=4, AFULL_THRESH=14, AEMPTY_THRESH=2):
- Reset, then 16 writes of 0x01..0x10 with r_en=0:
  - count steps 1..16.
  - almost_empty drops when count=3.
  - almost_full rises when count=14.
  - fifo_full=1 at count=16.
  - 17th write (0x11) -> overflow=1 for one cycle, count stays 16.
- From full, 16 reads:
  - Standard mode: data_out=0x01..0x10 in order, each one edge after its accepted read.
  - fifo_empty=1 after the 16th.
  - 17th read -> underflow pulse, data_out holds 0x10.
- Full FIFO, w_en=r_en=1 with data_in=0xAA for 3 cycles:
  - count stays 16, no overflow.
  - data_out=0x01,0x02,0x03.
  - 0xAA appears after the 0x10 entry.
- Empty FIFO, w_en=r_en=1 with data_in=0x55:
  - underflow pulse, count=1.
  - Next read returns 0x55.
- 5 writes, then flush_i=1 together with w_en=1:
  - count=0, fifo_empty=1, almost_empty=1, no overflow.
  - Subsequent write/read of 0x3C returns 0x3C (pointer wrap exercised by a 40-write/40-read stream with the values checked).
- FIFO_SYNC_FWFT_EN defined: write 0x77 into empty -> data_out=0x77 with fifo_empty=0 on the next cycle, before any r_en. One r_en -> fifo_empty=1.
- Assert reset_i between clock edges while count=7 -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty flags,
// overflow/underflow pulses and synchronous flush. FIFO_SYNC_FWFT_EN selects first-word-fall-through reads.
module fifo_sync_prog #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_BITS     = 4,
    parameter int AFULL_THRESH  = 2**ADDR_BITS - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] C_DEPTH  = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] C_AFULL  = AFULL_THRESH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] C_AEMPTY = AEMPTY_THRESH[ADDR_BITS:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_BITS:0]    r_wptr;
    logic [ADDR_BITS:0]    r_rptr;
    logic [ADDR_BITS:0]    r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_aempty;
    logic                  r_afull;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_ra;
    logic                  w_wa;
    logic [ADDR_BITS:0]    w_wptr_next;
    logic [ADDR_BITS:0]    w_rptr_next;
    logic [ADDR_BITS:0]    w_count_next;

    // A read frees a slot in the same edge, so a full FIFO can still take a write alongside it.
    always_comb begin
        w_ra         = r_en & ~r_empty & ~flush_i;
        w_wa         = w_en & (~r_full | w_ra) & ~flush_i;
        w_wptr_next  = r_wptr + {{ADDR_BITS{1'b0}}, w_wa};
        w_rptr_next  = r_rptr + {{ADDR_BITS{1'b0}}, w_ra};
        if (flush_i) begin
            w_wptr_next = '0;
            w_rptr_next = '0;
        end
        // Pointers carry one extra bit, so their difference is the fill level 0..DEPTH.
        w_count_next = w_wptr_next - w_rptr_next;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_next;
            r_rptr   <= w_rptr_next;
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            r_full   <= (w_count_next == C_DEPTH);
            r_aempty <= (w_count_next <= C_AEMPTY);
            r_afull  <= (w_count_next >= C_AFULL);
            r_ovf    <= ~flush_i & w_en & ~w_wa;
            r_udf    <= ~flush_i & r_en & r_empty;
        end
    end

    // Storage is never reset so it can map onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (w_wa) begin
            r_mem[r_wptr[ADDR_BITS-1:0]] <= data_in;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is presented continuously; r_en only acknowledges it.
    assign data_out = r_mem[r_rptr[ADDR_BITS-1:0]];
`else
    logic [DATA_WIDTH-1:0] r_dout;

    // Full FIFO with simultaneous write hits the same address; the read sees the old head.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_dout <= '0;
        end else if (w_ra) begin
            r_dout <= r_mem[r_rptr[ADDR_BITS-1:0]];
        end
    end

    assign data_out = r_dout;
`endif

    assign fifo_empty   = r_empty;
    assign fifo_full    = r_full;
    assign almost_empty = r_aempty;
    assign almost_full  = r_afull;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fifo_sync_prog;

    localparam int DW    = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic [DW-1:0] data_in;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic [AB:0]   count;
    logic          overflow;
    logic          underflow;

    always #5 clk_i = ~clk_i;

    fifo_sync_prog #(
        .DATA_WIDTH   (DW),
        .ADDR_BITS    (AB),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .data_in     (data_in),
        .w_en        (w_en),
        .r_en        (r_en),
        .data_out    (data_out),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are all functions of the fill level.
    task automatic check_status(input string tag, input int cnt, input bit ovf, input bit udf);
        check({tag, " count"},        32'(count),        32'(cnt));
        check({tag, " fifo_empty"},   32'(fifo_empty),   32'(cnt == 0));
        check({tag, " fifo_full"},    32'(fifo_full),    32'(cnt == DEPTH));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
        check({tag, " almost_full"},  32'(almost_full),  32'(cnt >= AF));
        check({tag, " overflow"},     32'(overflow),     32'(ovf));
        check({tag, " underflow"},    32'(underflow),    32'(udf));
    endtask

    task automatic drive(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
        flush_i = f;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        flush_i = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        #2;
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    // Directed vector table.
    typedef struct {
        bit            flush;
        bit            w;
        bit            r;
        logic [DW-1:0] d;
        int            cnt;
        bit            ovf;
        bit            udf;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit f, input bit w, input bit r, input logic [DW-1:0] d,
                                input int cnt, input bit ovf, input bit udf, input logic [DW-1:0] dout);
        vec_t v;
        v.flush = f; v.w = w; v.r = r; v.d = d;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.dout = dout;
        vecs.push_back(v);
    endfunction

    // Reference model: a queue of words plus the last popped word.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf;
    bit            m_udf;

    task automatic model_step(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
        bit was_empty;
        bit was_full;
        bit pop;
        bit push;
        if (f) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == DEPTH);
            pop       = r && !was_empty;
            push      = w && (!was_full || pop);
            if (pop) m_dout = m_q.pop_front();
            if (push) m_q.push_back(d);
            m_ovf = w && !push;
            m_udf = r && was_empty;
        end
    endtask

    initial begin
        logic [DW-1:0] prev;
        reset_i = 1'b0;
        do_reset();
        check_status("reset", 0, 0, 0);
        check("reset data_out", 32'(data_out), 32'h0);

        // Fill, overflow twice, drain, underflow.
        for (int i = 0; i < 16; i++) add(0, 1, 0, 8'(i + 1), i + 1, 0, 0, 8'h00);
        add(0, 1, 0, 8'h11, 16, 1, 0, 8'h00);
        add(0, 1, 0, 8'h12, 16, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 16, 0, 0, 8'h00);
        for (int k = 0; k < 16; k++) add(0, 0, 1, 8'h00, 15 - k, 0, 0, 8'(k + 1));
        add(0, 0, 1, 8'h00, 0, 0, 1, 8'h10);
        add(0, 0, 0, 8'h00, 0, 0, 0, 8'h10);
        // Refill, then read+write while full.
        for (int i = 0; i < 16; i++) add(0, 1, 0, 8'(i + 1), i + 1, 0, 0, 8'h10);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 8'hAA, 16, 0, 0, 8'(k + 1));
        for (int k = 3; k < 16; k++) add(0, 0, 1, 8'h00, 18 - k, 0, 0, 8'(k + 1));
        for (int k = 0; k < 3; k++) add(0, 0, 1, 8'h00, 2 - k, 0, 0, 8'hAA);
        // Empty with simultaneous read+write.
        add(0, 1, 1, 8'h55, 1, 0, 1, 8'hAA);
        add(0, 0, 1, 8'h00, 0, 0, 0, 8'h55);
        // Flush beats a same-cycle write and read.
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h20 + i), i + 1, 0, 0, 8'h55);
        add(1, 1, 1, 8'h99, 0, 0, 0, 8'h55);
        add(0, 1, 0, 8'h3C, 1, 0, 0, 8'h55);
        add(0, 0, 1, 8'h00, 0, 0, 0, 8'h3C);
        // Alternating stream long enough to wrap the pointers.
        prev = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            add(0, 1, 0, 8'(8'h40 + i), 1, 0, 0, prev);
            add(0, 0, 1, 8'h00, 0, 0, 0, 8'(8'h40 + i));
            prev = 8'(8'h40 + i);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].w, vecs[i].r, vecs[i].d);
            check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
`ifndef FIFO_SYNC_FWFT_EN
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
`endif
        end
        drive(0, 0, 0, 8'h00);
        $display("[TB] directed vectors applied: %0d", vecs.size());

`ifdef FIFO_SYNC_FWFT_EN
        // Word written into an empty FIFO is visible before any read request.
        do_reset();
        drive(0, 1, 0, 8'h77);
        check("fwft empty after write", 32'(fifo_empty), 32'h0);
        check("fwft data_out presented", 32'(data_out), 32'h77);
        drive(0, 0, 1, 8'h00);
        check("fwft empty after pop", 32'(fifo_empty), 32'h1);
        $display("[TB] fwft presentation sequence done");
`endif

        // Asynchronous reset between clock edges with seven words stored.
        do_reset();
        for (int i = 0; i < 7; i++) drive(0, 1, 1, 8'(8'h60 + i));
        check("pre-reset count", 32'(count), 32'd1);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 8'(8'h70 + i));
        check("pre-reset count 7", 32'(count), 32'd7);
        w_en = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        check_status("async reset", 0, 0, 0);
`ifndef FIFO_SYNC_FWFT_EN
        check("async reset data_out", 32'(data_out), 32'h0);
`endif
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        drive(0, 0, 1, 8'h00);
        check_status("after async reset read", 0, 0, 1);
        $display("[TB] async reset sequence done");

        // Randomized traffic against the queue model.
        do_reset();
        m_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            bit            f;
            bit            w;
            bit            r;
            logic [DW-1:0] d;
            int            wp;
            wp = ((i / 150) % 2 == 0) ? 80 : 25;
            f  = ($urandom_range(99) < 2);
            w  = ($urandom_range(99) < wp);
            r  = ($urandom_range(99) < 100 - wp);
            d  = 8'($urandom);
            drive(f, w, r, d);
            model_step(f, w, r, d);
            check_status($sformatf("rand%0d", i), m_q.size(), m_ovf, m_udf);
`ifdef FIFO_SYNC_FWFT_EN
            if (m_q.size() != 0) check($sformatf("rand%0d data_out", i), 32'(data_out), 32'(m_q[0]));
`else
            check($sformatf("rand%0d data_out", i), 32'(data_out), 32'(m_dout));
`endif
        end
        $display("[TB] random traffic done, final level %0d", m_q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
